interrupt_controller_v3: RTL
============================

# interrupt_controller_v3

Parametrised APB-slave interrupt controller with NUM_IRQ request lines. Each line has its own enable, edge/level mode and polarity, plus a pending latch. A fixed-priority claim register reports the winning source and acknowledges it. It drops into the same sockets as the 4-line controller: APB on one side, peripheral request lines on the other, a single interrupt output to the core.

## Interface

Parameters:
- NUM_IRQ, 8: number of request lines, 1..32.
- SYNC_STAGES, 2: synchroniser depth on irq_trigger_i, 2..3.

Ports:
- pclk_i  in  1  clock; sole clock, all logic on rising edge.
- rst_i  in  1  reset; synchronous, active-high.
- psel_i  in  1  APB select.
- penable_i  in  1  APB enable.
- pwrite_i  in  1  1 = write.
- paddr_i  in  32  byte address; only [7:2] decoded.
- pwdata_i  in  32  write data.
- prdata_o  out  32  read data, registered.
- pready_o  out  1  transfer complete.
- pslverr_o  out  1  transfer error, valid with pready_o.
- irq_trigger_i  in  NUM_IRQ  asynchronous request lines.
- enable_o  out  1  mirror of CTRL.GEN.
- interrupt_o  out  1  registered interrupt request to the core.

## Operation

Register map. Bits at and above NUM_IRQ read 0 and ignore writes.
- 0x00 CTRL, RW: bit0 GEN, the global enable.
- 0x04 IER, RW: per-line enable.
- 0x08 MODE, RW: 1 = edge, 0 = level.
- 0x0C POL, RW: 1 = active-low / falling edge.
- 0x10 IPR: read returns pending. Write-1-to-clear acts on edge lines only; level lines ignore the write.
- 0x14 CLAIM, RO: bit31 = valid, [4:0] = lowest index i with IPR[i] & IER[i]. Reads 0 when none. A read of a valid CLAIM clears IPR[id] if that line is edge mode.
- 0x18 RAW, RO: synchronised input levels, before polarity is applied.
- Any other offset: pslverr_o = 1, no state change, prdata_o = 0.
- A write to CLAIM or RAW: pslverr_o = 1, no state change.

Request path:
- s = irq_trigger_i after SYNC_STAGES flops, then XOR with POL.
- Edge line: IPR[i] sets on a 0→1 transition of s[i]. A delayed copy of s provides the previous value.
- Level line: IPR[i] = s[i], re-evaluated every cycle.
- IPR latches regardless of IER. IER only gates interrupt_o and CLAIM.
- interrupt_o <= GEN & |(IPR & IER).

Boundary rules:
- An edge-set and a clear (W1C or claim) on the same line in the same cycle: set wins, IPR stays 1.
- Changing MODE from edge to level: the line immediately follows s.
- Changing MODE from level to edge: IPR is cleared that cycle. The previous-value flop is not reset, so a held-high input does not re-trigger.
- Writing POL can create a synthetic edge. That is accepted behaviour: the edge sets IPR.
- GEN = 0 masks interrupt_o only. Pending keeps latching.

## Timing

- Reset (rst_i high at an edge): all registers 0; prdata_o = 0, pready_o = 0, pslverr_o = 0, interrupt_o = 0, enable_o = 0. The synchroniser and edge flops also clear.
- Reset mid-transfer aborts the transfer. pready_o stays 0 until a new setup phase.
- APB transfers take one wait state:
  - Setup cycle: psel = 1, penable = 0.
  - Access cycle 1: pready_o = 0.
  - Access cycle 2: pready_o = 1, with prdata_o and pslverr_o valid.
  - pready_o is high for exactly one cycle, then returns to 0.
- A write commits at the edge ending the pready_o = 1 cycle. The CLAIM side-effect commits at the same edge.
- A read samples register state at the edge entering the pready_o cycle.
- psel_i dropping mid-access: the transfer is abandoned, with no write and no side-effect.
- Request latency (SYNC_STAGES = 2), for an input that changes before edge 0:
  - IPR updates at edge 3.
  - interrupt_o updates at edge 4.
- Register-write latency: a write to IER/GEN commits at edge E, and interrupt_o reflects it at edge E+1.
- enable_o changes at the commit edge.
- Inputs are assumed stable for at least SYNC_STAGES + 1 cycles. Pulses shorter than that may be missed.

## Test plan

- Reset and idle: reset 2 cycles → all outputs 0. Read 0x00..0x18 → all read 0 except RAW; RAW reads 0 once inputs have been held low for ≥3 cycles. pslverr_o = 0 throughout.
- Edge claim priority: MODE = 0xFF, IER = 0xFF, GEN = 1; pulse lines 5 and 2 together (4 cycles) → IPR = 0x24, interrupt_o high 4 cycles after the edge. CLAIM reads 0x8000_0002, then 0x8000_0005, then 0x0000_0000; interrupt_o falls after the second claim.
- Level with polarity: MODE = 0, POL = 0x01, IER = 0x01, GEN = 1; irq_trigger_i[0] = 1 → no interrupt. Drive 0 → interrupt_o = 1 after 4 cycles. A W1C to IPR[0] leaves it set.
- Set wins over clear: line 3 edge mode; time a rising edge on line 3 to land in the same cycle as the W1C 0x08 commit → IPR[3] = 1 afterwards.
- Masking: IPR[1] pending, IER = 0 → interrupt_o = 0 and CLAIM = 0. Write IER = 0x02 → interrupt_o = 1 one cycle after commit. Write GEN = 0 → interrupt_o = 0 and enable_o = 0.
- Errors and abort: write to 0x14 and read of 0x40 → pslverr_o = 1, state unchanged. Assert rst_i during access cycle 1 → no pready_o pulse, all registers 0.

Source files
------------

// File: rtl/interrupt_controller_v3.sv
// APB-slave interrupt controller: NUM_IRQ request lines with per-line enable,
// edge/level mode, polarity and pending latch, plus a fixed-priority claim register.
//
// state    | meaning
// ST_IDLE  | no transfer in progress, waiting for a setup phase
// ST_WAIT  | access cycle 1 (wait state), pready_o low, read data sampled at exit
// ST_READY | access cycle 2, pready_o high, writes/claim commit at exit
module interrupt_controller_v3 #(
    parameter int NUM_IRQ     = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic               pclk_i,
    input  logic               rst_i,
    input  logic               psel_i,
    input  logic               penable_i,
    input  logic               pwrite_i,
    input  logic [31:0]        paddr_i,
    input  logic [31:0]        pwdata_i,
    output logic [31:0]        prdata_o,
    output logic               pready_o,
    output logic               pslverr_o,
    input  logic [NUM_IRQ-1:0] irq_trigger_i,
    output logic               enable_o,
    output logic               interrupt_o
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_READY
    } apb_state_t;

    localparam logic [5:0] OFF_CTRL  = 6'd0;
    localparam logic [5:0] OFF_IER   = 6'd1;
    localparam logic [5:0] OFF_MODE  = 6'd2;
    localparam logic [5:0] OFF_POL   = 6'd3;
    localparam logic [5:0] OFF_IPR   = 6'd4;
    localparam logic [5:0] OFF_CLAIM = 6'd5;
    localparam logic [5:0] OFF_RAW   = 6'd6;

    apb_state_t state_q, state_n;

    logic [NUM_IRQ-1:0] sync_q [SYNC_STAGES];
    logic [NUM_IRQ-1:0] raw;
    logic [NUM_IRQ-1:0] s_q, s_prev_q, rise;
    logic               gen_q;
    logic [NUM_IRQ-1:0] ier_q, mode_q, pol_q, ipr_q;
    logic [NUM_IRQ-1:0] mode_n, ipr_n, active, w1c, claim_clr, clr;

    logic [5:0]  offset;
    logic [31:0] rd_data;
    logic        rd_err;
    logic        claim_valid;
    logic [4:0]  claim_id;

    logic [5:0]  sel_q;
    logic        wr_q, err_q, claim_hit_q;
    logic [4:0]  claim_id_q;
    logic        sample, commit;
    logic        we_ctrl, we_ier, we_mode, we_pol, we_ipr;

    logic unused_apb;
    assign unused_apb = &{1'b0, paddr_i[31:8], paddr_i[1:0], pwdata_i};

    assign offset   = paddr_i[7:2];
    assign raw      = sync_q[SYNC_STAGES-1];
    assign rise     = s_q & ~s_prev_q;
    assign active   = ipr_q & ier_q;
    assign pready_o = (state_q == ST_READY);
    assign enable_o = gen_q;

    always_ff @(posedge pclk_i) begin
        if (rst_i) begin
            for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
        end else begin
            sync_q[0] <= irq_trigger_i;
            for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
        end
    end

    // Lowest index wins: scan downward so the last hit is the smallest.
    always_comb begin
        claim_valid = |active;
        claim_id    = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (active[i]) claim_id = 5'(i);
        end
    end

    always_comb begin
        rd_data = '0;
        rd_err  = 1'b0;
        case (offset)
            OFF_CTRL:  rd_data[0] = gen_q;
            OFF_IER:   rd_data[NUM_IRQ-1:0] = ier_q;
            OFF_MODE:  rd_data[NUM_IRQ-1:0] = mode_q;
            OFF_POL:   rd_data[NUM_IRQ-1:0] = pol_q;
            OFF_IPR:   rd_data[NUM_IRQ-1:0] = ipr_q;
            OFF_CLAIM: begin
                rd_data[31]  = claim_valid;
                rd_data[4:0] = claim_id;
                rd_err       = pwrite_i;
            end
            OFF_RAW: begin
                rd_data[NUM_IRQ-1:0] = raw;
                rd_err               = pwrite_i;
            end
            default:   rd_err = 1'b1;
        endcase
    end

    always_comb begin
        state_n = state_q;
        case (state_q)
            ST_IDLE:  if (psel_i && !penable_i) state_n = ST_WAIT;
            ST_WAIT:  state_n = (psel_i && penable_i) ? ST_READY : ST_IDLE;
            ST_READY: state_n = ST_IDLE;
            default:  state_n = ST_IDLE;
        endcase
    end

    assign sample = (state_q == ST_WAIT) && psel_i && penable_i;
    assign commit = (state_q == ST_READY) && psel_i && penable_i && !err_q;

    always_ff @(posedge pclk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            prdata_o    <= '0;
            pslverr_o   <= 1'b0;
            sel_q       <= '0;
            wr_q        <= 1'b0;
            err_q       <= 1'b0;
            claim_hit_q <= 1'b0;
            claim_id_q  <= '0;
        end else begin
            state_q <= state_n;
            if (sample) begin
                prdata_o    <= pwrite_i ? '0 : rd_data;
                pslverr_o   <= rd_err;
                sel_q       <= offset;
                wr_q        <= pwrite_i;
                err_q       <= rd_err;
                claim_hit_q <= !pwrite_i && (offset == OFF_CLAIM) && claim_valid;
                claim_id_q  <= claim_id;
            end else begin
                prdata_o  <= '0;
                pslverr_o <= 1'b0;
            end
        end
    end

    assign we_ctrl = commit && wr_q && (sel_q == OFF_CTRL);
    assign we_ier  = commit && wr_q && (sel_q == OFF_IER);
    assign we_mode = commit && wr_q && (sel_q == OFF_MODE);
    assign we_pol  = commit && wr_q && (sel_q == OFF_POL);
    assign we_ipr  = commit && wr_q && (sel_q == OFF_IPR);

    assign mode_n = we_mode ? pwdata_i[NUM_IRQ-1:0] : mode_q;
    assign w1c    = we_ipr ? pwdata_i[NUM_IRQ-1:0] : '0;
    assign clr    = w1c | claim_clr;

    // The claimed id is the one captured with the read data, not a re-evaluation.
    always_comb begin
        claim_clr = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            claim_clr[i] = commit && claim_hit_q && (claim_id_q == 5'(i));
        end
    end

    // Level lines follow s under the new mode; a level-to-edge switch starts clean.
    always_comb begin
        ipr_n = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (!mode_n[i])      ipr_n[i] = s_q[i];
            else if (!mode_q[i]) ipr_n[i] = 1'b0;
            else                 ipr_n[i] = rise[i] | (ipr_q[i] & ~clr[i]);
        end
    end

    always_ff @(posedge pclk_i) begin
        if (rst_i) begin
            s_q         <= '0;
            s_prev_q    <= '0;
            gen_q       <= 1'b0;
            ier_q       <= '0;
            mode_q      <= '0;
            pol_q       <= '0;
            ipr_q       <= '0;
            interrupt_o <= 1'b0;
        end else begin
            s_q         <= raw ^ pol_q;
            s_prev_q    <= s_q;
            ipr_q       <= ipr_n;
            mode_q      <= mode_n;
            if (we_ctrl) gen_q <= pwdata_i[0];
            if (we_ier)  ier_q <= pwdata_i[NUM_IRQ-1:0];
            if (we_pol)  pol_q <= pwdata_i[NUM_IRQ-1:0];
            interrupt_o <= gen_q & |(ipr_q & ier_q);
        end
    end

endmodule
